alu_req_scheduler: RTL

- Shares one 8-bit ALU datapath between two requesters and sequences each operation to completion.
- Each requester presents an operation with a valid/ready handshake. The scheduler grants one requester at a time using round-robin or fixed priority.
- Single-cycle ops complete in one execute cycle. MUL runs as a WIDTH-cycle shift-add sequence.
- Results return on a single response channel tagged with the requester id. The block sits between the chip's input decode logic and the uo_out/uio_out result muxing.

---
 rtl/alu_req_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_req_scheduler.sv
// Two-requester scheduler sharing one ALU datapath: arbitrates, executes single-cycle ops
// or a WIDTH-cycle shift-add multiply, and returns a tagged result on one response channel.
module alu_req_scheduler #(
    parameter int WIDTH = 8,
    parameter int FAIR  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_op,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_op,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_last_grant;
    logic                 r_id;
    logic [2:0]           r_op;
    logic [2*WIDTH-1:0]   r_a;        // operand A; shifts left as the multiplicand
    logic [WIDTH-1:0]     r_b;        // operand B; shifts right as the multiplier
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_carry;
    logic                 r_zero;

    logic                 w_grant_id;
    logic                 w_accept;
    logic [2:0]           w_op;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [SHW-1:0]       w_sh;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_carry;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_mul_last;

    // Arbitration: a lone requester wins; on a tie round-robin or fixed req0 priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_grant_id = req1_valid;
        if (req0_valid && req1_valid)
            w_grant_id = (FAIR != 0) ? ~r_last_grant : 1'b0;
        w_accept = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
        w_op     = w_grant_id ? req1_op : req0_op;
        w_a      = w_grant_id ? req1_a  : req0_a;
        w_b      = w_grant_id ? req1_b  : req0_b;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = (w_op == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: w_next_state = S_RESP;
            S_MUL:  if (w_mul_last) w_next_state = S_RESP;
            S_RESP: if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req0_ready = w_accept && !w_grant_id;
        req1_ready = w_accept && w_grant_id;
        rsp_valid  = (r_state == S_RESP);
        busy       = (r_state != S_IDLE);
    end

    // Single-cycle ALU; shift carries fall out of one extra bit on the shifted side.
    always_comb begin
        w_sh        = r_b[SHW-1:0];
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (r_op)
            OP_ADD: {w_alu_carry, w_alu_res} = {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_b};
            OP_SUB: {w_alu_carry, w_alu_res} = {1'b0, r_a[WIDTH-1:0]} - {1'b0, r_b};
            OP_AND: w_alu_res = r_a[WIDTH-1:0] & r_b;
            OP_OR:  w_alu_res = r_a[WIDTH-1:0] | r_b;
            OP_XOR: w_alu_res = r_a[WIDTH-1:0] ^ r_b;
            OP_SHL: {w_alu_carry, w_alu_res} = {1'b0, r_a[WIDTH-1:0]} << w_sh;
            OP_SHR: {w_alu_res, w_alu_carry} = {r_a[WIDTH-1:0], 1'b0} >> w_sh;
            default: w_alu_res = '0;
        endcase
        w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;
        w_mul_last = (r_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= OP_ADD;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_carry      <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op         <= w_op;
                    r_a          <= {{WIDTH{1'b0}}, w_a};
                    r_b          <= w_b;
                    r_id         <= w_grant_id;
                    r_last_grant <= w_grant_id;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                end
                S_EXEC: begin
                    r_result <= {{WIDTH{1'b0}}, w_alu_res};
                    r_carry  <= w_alu_carry;
                    r_zero   <= (w_alu_res == '0);
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_result <= w_acc_next;
                        r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero   <= (w_acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
    assign rsp_zero   = r_zero;

endmodule
